keypad_scan4: RTL and testbench
===============================

Name: keypad_scan4

Overview:
- 4x4 matrix keypad scanner; the input-side counterpart of the 4-digit seven-segment scan driver.
- Drives one keypad column low at a time, samples the active-low row lines, and debounces over whole scan frames.
- Emits a one-cycle key event with a 4-bit hex code.
- Keeps a 16-bit, 4-digit shift buffer that feeds the display's digit inputs directly: bits [3:0] = rightmost digit.

Parameters:
- SCAN_DIV, 2000, clk cycles each column is driven; must be >= 4.
- DEBOUNCE_CNT, 3, consecutive identical frames required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- row  input  4  keypad rows, active-low, pulled up, asynchronous to clk
- clr  input  1  synchronous clear of key_buf, active-high
- col  output  4  column drive, active-low one-cold
- key_valid  output  1  one-cycle pulse per accepted press
- key_code  output  4  code of last accepted key, held between presses
- key_down  output  1  high while an accepted key is considered held
- key_buf  output  16  last four accepted codes; newest in [3:0]

Behaviour:
- Reset (rst=0, asynchronous): col=4'b1110, key_valid=0, key_code=0, key_down=0, key_buf=0, FSM=IDLE. Divider, column index, frame map and debounce counter all cleared.
- row passes through a 2-flop synchronizer before any use.
- Divider div counts 0..SCAN_DIV-1 and wraps.
- col = ~(4'b0001 << idx).
- When div==SCAN_DIV-1:
  - the synchronized row is sampled for the current column;
  - idx advances 0->1->2->3->0.
- Key index = row_bit*4 + col_idx (row0/col0 = 0x0, row3/col3 = 0xF). A key is pressed when its row bit reads 0 while its column is driven.
- A frame is four column samples. It ends at the sample edge with idx==3; the full 16-bit map, including that last sample, is evaluated at this edge. The map accumulator clears for the next frame.
- Frame classification:
  - NONE: map == 0.
  - SINGLE(k): exactly one bit set.
  - MULTI: two or more bits set.
- FSM, evaluated only at frame-end edges:
  - IDLE:
    - SINGLE(k) -> DEBOUNCE with cand=k, cnt=1.
    - If DEBOUNCE_CNT==1, go straight to PRESSED and accept instead.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1; when it reaches DEBOUNCE_CNT -> PRESSED and accept.
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - PRESSED:
    - SINGLE (any key) or MULTI -> stay; no rollover, no second event.
    - NONE -> RELEASE with cnt=1; if DEBOUNCE_CNT==1 -> IDLE directly.
  - RELEASE:
    - NONE -> cnt+1; when it reaches DEBOUNCE_CNT -> IDLE.
    - Any key -> PRESSED (bounce absorbed, no new event).
- Accept, registered so outputs change at the frame-end edge:
  - key_code=cand and key_down=1;
  - key_valid=1 for exactly one clk, cleared the next edge;
  - key_buf <= {key_buf[11:0], cand}.
- key_down falls at the edge where the FSM enters IDLE from RELEASE.
- clr=1 sets key_buf=0. clr wins over a simultaneous accept: key_buf=0, but key_valid and key_code still update.
- key_valid is never asserted outside an accept edge. Press-to-pulse latency is DEBOUNCE_CNT full frames, plus up to one partial frame, plus 2 sync cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2; frame = 16 cycles):
- Reset release, no keys -> col cycles 1110,1101,1011,0111, each for 4 clks; key_valid never 1; key_buf=0x0000.
- Hold row1/col2 low, starting before a frame begins -> key_valid pulses once at the end of the 2nd full frame; key_code=0x6; key_down=1; key_buf=0x0006.
- Keep holding for 10 frames, then release -> no further pulses; key_down falls at the end of the 2nd empty frame.
- Enter 1,2,3,4,5 (row0/col1, row0/col2, row0/col3, row1/col0, row1/col1) with full release between keys -> key_buf=0x2345.
- Press toggling every other frame, and separately two keys held together -> no key_valid in either case; FSM returns to IDLE.
- Pull rst low mid-DEBOUNCE, then clr asserted in the same cycle as an accept -> reset: all outputs 0 and col=1110 immediately. clr case: key_buf=0x0000 while key_valid=1 with the new key_code.

Source files
------------

// File: rtl/keypad_scan4.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces whole frames, emits hex key events.
// Latency: DEBOUNCE_CNT full frames plus up to one partial frame plus 2 sync cycles from press to key_valid.
// No backpressure: key_valid is a one-cycle pulse; key_code, key_down and key_buf hold their values until changed.
module keypad_scan4 #(
  parameter int SCAN_DIV     = 2000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [15:0] key_buf
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [15:0]   map;
  logic [15:0]   hits;
  logic [15:0]   frame_map;
  logic          sample;
  logic          frame_end;
  logic          any_key;
  logic          multi;
  logic          single;
  logic          none;
  logic [3:0]    kidx;
  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  // Rows come straight from switches: two flops before anything looks at them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign sample    = (div == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (idx == 2'd3);
  assign col       = ~(4'b0001 << idx);

  // Place this column's pressed rows into the map and classify the frame including the current sample.
  always_comb begin
    hits    = '0;
    any_key = 1'b0;
    multi   = 1'b0;
    kidx    = 4'd0;
    for (int r = 0; r < 4; r++) begin
      hits[{2'(r), idx}] = ~row_sync[r];
    end
    frame_map = map | hits;
    for (int i = 0; i < 16; i++) begin
      if (frame_map[4'(i)]) begin
        if (any_key) multi = 1'b1;
        any_key = 1'b1;
        kidx    = 4'(i);
      end
    end
    none   = !any_key;
    single = any_key && !multi;
  end

  // Column timing and per-frame map accumulation; the map restarts after the last column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= 2'd0;
      map <= '0;
    end else if (sample) begin
      div <= '0;
      idx <= idx + 2'd1;
      map <= frame_end ? 16'h0000 : frame_map;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Debounce FSM with registered outputs; only frame-end edges move it, clr overrides any buffer push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_down  <= 1'b0;
      key_buf   <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (single) begin
              cand <= kidx;
              cnt  <= CW'(1);
              if (DEBOUNCE_CNT == 1) begin
                state     <= PRESSED;
                key_code  <= kidx;
                key_down  <= 1'b1;
                key_valid <= 1'b1;
                key_buf   <= {key_buf[11:0], kidx};
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (single && kidx == cand) begin
              if (cnt + 1'b1 == CW'(DEBOUNCE_CNT)) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_down  <= 1'b1;
                key_valid <= 1'b1;
                key_buf   <= {key_buf[11:0], cand};
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (single) begin
              cand <= kidx;
              cnt  <= CW'(1);
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (none) begin
              if (DEBOUNCE_CNT == 1) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASE: begin
            if (none) begin
              if (cnt + 1'b1 == CW'(DEBOUNCE_CNT)) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (clr) key_buf <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_keypad_scan4.sv
// Bench for keypad_scan4 with a switch-matrix model driving the rows from the DUT's columns.
// Latency: expected key codes are queued at press time and popped when key_valid fires.
// No backpressure: the DUT is free-running; every wait is bounded.
module tb_keypad_scan4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] key_buf;

  logic [15:0] keys = 16'h0000;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic [15:0] model_buf = 16'h0000;
  logic        clr_seen = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;

  always #5 clk = ~clk;

  // Switch matrix: a row reads low when a pressed key on it sits in a driven column.
  assign row[0] = ~|(keys[3:0]   & ~col);
  assign row[1] = ~|(keys[7:4]   & ~col);
  assign row[2] = ~|(keys[11:8]  & ~col);
  assign row[3] = ~|(keys[15:12] & ~col);

  keypad_scan4 #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk(clk), .rst(rst), .row(row), .clr(clr), .col(col),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down), .key_buf(key_buf)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) clr_seen <= clr;

  // Scoreboard: every pulse must match the oldest queued press; key_buf follows the shift/clear model.
  always @(negedge clk) begin
    if (rst) begin
      if (key_valid) begin
        pulses++;
        chk("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_code = exp_q.pop_front();
          chk("key_code", 32'(key_code), 32'(exp_code));
          chk("key_down_on_pulse", 32'(key_down), 1);
          model_buf = {model_buf[11:0], exp_code};
        end
      end
      if (clr_seen) model_buf = 16'h0000;
      if (key_valid || clr_seen) chk("key_buf", 32'(key_buf), 32'(model_buf));
    end
  end

  // Returns at the first negedge of a new frame (column 0 just driven).
  task automatic goto_frame_start();
    int n;
    n = 0;
    while (col !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (col !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("frame_sync_timeout", 32'(n), 0);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) goto_frame_start();
  endtask

  task automatic press_key(input logic [3:0] k);
    goto_frame_start();
    keys = 16'h0000;
    keys[k] = 1'b1;
    exp_q.push_back(k);
    wait_frames(3);
    keys = 16'h0000;
    wait_frames(3);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    int first;
    int p0;

    #23;
    @(negedge clk);
    chk("rst_col", 32'(col), 32'(4'b1110));
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_down", 32'(key_down), 0);
    chk("rst_buf", 32'(key_buf), 0);
    rst = 1'b1;

    // Column walk right after reset, four clocks per column.
    for (int j = 0; j < 16; j++) begin
      ec = ~(4'b0001 << (j / 4));
      chk("col_seq", 32'(col), 32'(ec));
      @(negedge clk);
    end
    chk("idle_buf", 32'(key_buf), 0);

    // Row1/col2 held from a frame start: one pulse at the end of the second frame.
    goto_frame_start();
    keys[6] = 1'b1;
    exp_q.push_back(4'h6);
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (key_valid && first < 0) first = i;
      if (i == 31) chk("down_before_accept", 32'(key_down), 0);
    end
    chk("first_pulse_cycle", 32'(first), 32);
    chk("first_pulse_count", 32'(pulses), 1);
    chk("held_down", 32'(key_down), 1);
    chk("held_code", 32'(key_code), 32'h6);
    chk("held_buf", 32'(key_buf), 32'h0006);

    // Long hold, then release: key_down drops at the end of the second empty frame.
    p0 = pulses;
    wait_frames(10);
    keys = 16'h0000;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 31) chk("down_before_release", 32'(key_down), 1);
      if (i == 32) chk("down_after_release", 32'(key_down), 0);
    end
    chk("no_repeat_pulse", 32'(pulses), 32'(p0));

    // Five keys with full releases in between.
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    press_key(4'h5);
    chk("seq_buf", 32'(key_buf), 32'h2345);
    chk("seq_pulses", 32'(pulses), 6);

    // Bouncy press toggling every frame, then a two-key chord: neither is accepted.
    p0 = pulses;
    repeat (4) begin
      goto_frame_start();
      keys[9] = 1'b1;
      goto_frame_start();
      keys = 16'h0000;
    end
    wait_frames(2);
    goto_frame_start();
    keys = 16'h0021;
    wait_frames(6);
    keys = 16'h0000;
    wait_frames(2);
    chk("bounce_chord_pulses", 32'(pulses), 32'(p0));
    chk("bounce_chord_down", 32'(key_down), 0);
    chk("bounce_chord_buf", 32'(key_buf), 32'h2345);

    // Reset while debouncing key 3: everything clears at once.
    goto_frame_start();
    keys[3] = 1'b1;
    goto_frame_start();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_col", 32'(col), 32'(4'b1110));
    chk("arst_valid", 32'(key_valid), 0);
    chk("arst_code", 32'(key_code), 0);
    chk("arst_down", 32'(key_down), 0);
    chk("arst_buf", 32'(key_buf), 0);
    model_buf = 16'h0000;
    keys = 16'h0000;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    wait_frames(3);
    chk("post_reset_pulses", 32'(pulses), 32'(p0));

    // clr in the accept cycle: buffer cleared, event still reported.
    goto_frame_start();
    keys[10] = 1'b1;
    exp_q.push_back(4'hA);
    repeat (31) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_accept_valid", 32'(key_valid), 1);
    chk("clr_accept_code", 32'(key_code), 32'hA);
    chk("clr_accept_buf", 32'(key_buf), 0);
    keys = 16'h0000;
    wait_frames(3);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
